// File: rtl/shop_pkg.sv
// Shared types and constants for the shop session arbiter slice.
package shop_pkg;
    localparam int SHOP_W = 4;

    localparam logic [SHOP_W-1:0] DISP_BALANCE = 4'd1;
    localparam logic [SHOP_W-1:0] DISP_STOCK   = 4'd0;
    localparam logic [SHOP_W-1:0] ITEM_NONE    = 4'd0;

    typedef enum logic [2:0] {IDLE, MAINT, SESSION, CLOSE, DONE} state_t;

    typedef struct packed {
        logic [SHOP_W-1:0] money;
        logic [SHOP_W-1:0] buy;
        logic              close;
    } panel_t;
endpackage

// File: rtl/shop_rr_arb.sv
// Two-way round-robin picker: on a tie the panel not served last wins.
module shop_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);
    always_comb begin
        pick = req;
        if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/shop_session_arbiter.sv
// Shares the shop core between two customer panels and a maintenance port,
// one whole purchase session at a time; all outputs are registered.
module shop_session_arbiter
    import shop_pkg::*;
#(
    parameter int TIMEOUT      = 15,
    parameter int CLOSE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [SHOP_W-1:0] p0_money,
    input  logic [SHOP_W-1:0] p1_money,
    input  logic [SHOP_W-1:0] p0_buy,
    input  logic [SHOP_W-1:0] p1_buy,
    input  logic              p0_close,
    input  logic              p1_close,
    input  logic              mnt_req,
    input  logic [SHOP_W-1:0] mnt_set,
    input  logic [SHOP_W-1:0] mnt_quantity,
    input  logic [SHOP_W-1:0] mnt_price,
    input  logic [SHOP_W-1:0] core_goods,
    input  logic [SHOP_W-1:0] core_balance,
    output logic [1:0]        grant,
    output logic              mnt_grant,
    output logic              busy,
    output logic [SHOP_W-1:0] core_money,
    output logic [SHOP_W-1:0] core_buy,
    output logic [SHOP_W-1:0] core_set,
    output logic [SHOP_W-1:0] core_set_quantity,
    output logic [SHOP_W-1:0] core_set_price,
    output logic [SHOP_W-1:0] core_display,
    output logic              core_close,
    output logic [1:0]        ret_valid,
    output logic [SHOP_W-1:0] ret_goods,
    output logic [SHOP_W-1:0] ret_balance
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT);
    localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYCLES - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] idle_cnt;
    logic [CW-1:0] close_cnt;
    logic          rr_last;
    logic [1:0]    pick;
    panel_t        pan;
    logic          active, close_cause;

    shop_rr_arb u_rr (
        .req  (req),
        .last (rr_last),
        .pick (pick)
    );

    // grant is stable for the whole session, so it selects the owner's inputs
    always_comb begin
        pan = '{money: p0_money, buy: p0_buy, close: p0_close};
        if (grant[1]) pan = '{money: p1_money, buy: p1_buy, close: p1_close};
    end

    // core_money holds the owner's money from the previous cycle
    assign active      = (pan.buy != ITEM_NONE) || (pan.money != core_money);
    assign close_cause = pan.close || (idle_cnt == IDLE_MAX) || !req[grant[1]];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mnt_req) state_nxt = MAINT;
                     else if (|req) state_nxt = SESSION;
            MAINT:   if (!mnt_req) state_nxt = IDLE;
            SESSION: if (close_cause) state_nxt = CLOSE;
            CLOSE:   if (close_cnt == CLOSE_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            idle_cnt          <= '0;
            close_cnt         <= '0;
            rr_last           <= 1'b1;
            grant             <= '0;
            mnt_grant         <= 1'b0;
            busy              <= 1'b0;
            core_money        <= '0;
            core_buy          <= '0;
            core_set          <= '0;
            core_set_quantity <= '0;
            core_set_price    <= '0;
            core_display      <= '0;
            core_close        <= 1'b0;
            ret_valid         <= '0;
            ret_goods         <= '0;
            ret_balance       <= '0;
        end else begin
            state             <= state_nxt;
            busy              <= (state != IDLE);
            mnt_grant         <= (state_nxt == MAINT);
            core_close        <= (state_nxt == CLOSE);
            core_display      <= (state_nxt == SESSION) ? DISP_BALANCE : DISP_STOCK;
            core_buy          <= (state == SESSION && state_nxt == SESSION) ? pan.buy : ITEM_NONE;
            core_set          <= (state == MAINT) ? mnt_set      : '0;
            core_set_quantity <= (state == MAINT) ? mnt_quantity : '0;
            core_set_price    <= (state == MAINT) ? mnt_price    : '0;
            ret_valid         <= '0;

            // money keeps its last value through the close phase
            if (state == SESSION) core_money <= pan.money;
            else if (state != CLOSE) core_money <= '0;

            if (state == SESSION) begin
                if (active) idle_cnt <= '0;
                else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            close_cnt <= (state == CLOSE) ? close_cnt + 1'b1 : '0;

            if (state == IDLE && state_nxt == SESSION) grant <= pick;

            if (state == DONE) begin
                ret_valid   <= grant;
                ret_goods   <= core_goods;
                ret_balance <= core_balance;
                rr_last     <= grant[1];
                grant       <= '0;
            end
        end
    end
endmodule
